pipelined_cla_adder: RTL and testbench

Two-stage pipelined, parametrised carry-lookahead adder/subtractor with valid/ready flow control on both sides. It is the datapath-grade successor to the single-cycle combinational CLA. It splits the word into lookahead groups, registers group propagate/generate after stage 1, and resolves group carries and sums in stage 2. It sits between operand-issue logic and any consumer that may stall, so it sustains one operation per cycle under backpressure.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_group.sv | 63 ++++++
 rtl/pipelined_cla_adder.sv | 207 ++++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   OP_ADD / OP_SUB     : encoding of the adder's sub input
//   GRP_MODE_PG/SUM     : tie-off values selecting the cla_group mode
//   numgroups()         : number of lookahead groups in a word
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // cla_group mode tie-offs: first level (p/g -> GP/GG) or sum formation
  localparam logic GRP_MODE_PG  = 1'b0;
  localparam logic GRP_MODE_SUM = 1'b1;

  function automatic int numgroups(input int numbits, input int groupbits);
    return numbits / groupbits;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUPBITS-wide lookahead group. The mode port is tied off by the
// instantiating logic:
//   GRP_MODE_PG  : gp = AND of p, gg = group generate (cin/sum unused, sum = 0)
//   GRP_MODE_SUM : sum = p ^ internal carries rippled from cin (gp/gg = 0)
// Ports:
//   mode  in   group function select
//   p, g  in   per-bit propagate / generate
//   cin   in   carry into the group's LSB
//   gp    out  group propagate
//   gg    out  group generate
//   sum   out  group sum bits
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUPBITS = 4
) (
  input  logic                 mode,
  input  logic [GROUPBITS-1:0] p,
  input  logic [GROUPBITS-1:0] g,
  input  logic                 cin,
  output logic                 gp,
  output logic                 gg,
  output logic [GROUPBITS-1:0] sum
);

  logic                 gp_s;
  logic                 gg_s;
  logic [GROUPBITS-1:0] sum_s;

  // Group propagate/generate and in-group carry chain, then gate by mode
  always_comb begin
    logic carry_v;
    gp_s    = 1'b1;
    gg_s    = 1'b0;
    sum_s   = '0;
    carry_v = cin;
    gp      = 1'b0;
    gg      = 1'b0;
    sum     = '0;
    for (int i = 0; i < GROUPBITS; i++) begin
      gp_s     = gp_s & p[i];
      // gg: a carry generated at bit i survives every higher propagate bit
      gg_s     = g[i] | (p[i] & gg_s);
      sum_s[i] = p[i] ^ carry_v;
      carry_v  = g[i] | (p[i] & carry_v);
    end
    case (mode)
      GRP_MODE_PG: begin
        gp = gp_s;
        gg = gg_s;
      end
      GRP_MODE_SUM: begin
        sum = sum_s;
      end
      default: begin
        gp  = 1'b0;
        gg  = 1'b0;
        sum = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// flow control on both sides.
//   Stage 1: forms Beff / cin_eff, registers per-bit p/g and per-group GP/GG.
//   Stage 2: second-level lookahead over GP/GG, group sums, registered result.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready depends on out_ready)
//   A, B, carryin, sub  operands; sub=1 computes A-B and ignores carryin
//   out_valid, out_ready result handshake
//   result, carryout    registered sum and carry out of the MSB
//   overflow            signed overflow, only when CLA_OVERFLOW_EN is defined
// Optional feature macro: CLA_OVERFLOW_EN
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int NUMBITS   = 16,
  parameter int GROUPBITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               carryin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] result,
  output logic               carryout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam int NUMGROUPS = numgroups(NUMBITS, GROUPBITS);

  if ((GROUPBITS < 1) || ((NUMBITS % GROUPBITS) != 0)) begin : g_bad_cfg
    $error("pipelined_cla_adder: NUMBITS must be a positive multiple of GROUPBITS");
  end

  // Flow control
  logic s2_take_s;
  logic s1_take_s;
  logic accept_s;
  logic advance_s;

  // Stage 1 combinational / registered
  logic [NUMBITS-1:0]   b_eff_s;
  logic                 cin_eff_s;
  logic [NUMBITS-1:0]   p_s;
  logic [NUMBITS-1:0]   g_s;
  logic [NUMGROUPS-1:0] gp_s;
  logic [NUMGROUPS-1:0] gg_s;
  logic [NUMBITS-1:0]   unused_s1_sum_s;

  logic                 s1_valid_r;
  logic [NUMBITS-1:0]   s1_p_r;
  logic [NUMBITS-1:0]   s1_g_r;
  logic [NUMGROUPS-1:0] s1_gp_r;
  logic [NUMGROUPS-1:0] s1_gg_r;
  logic                 s1_cin_r;

  // Stage 2 combinational / registered
  logic [NUMGROUPS:0]   grp_c_s;
  logic [NUMBITS-1:0]   sum_s;
  logic [NUMGROUPS-1:0] unused_s2_gp_s;
  logic [NUMGROUPS-1:0] unused_s2_gg_s;

  logic                 s2_valid_r;
  logic [NUMBITS-1:0]   result_r;
  logic                 carryout_r;

`ifdef CLA_OVERFLOW_EN
  logic                 s1_a_msb_r;
  logic                 ovf_s;
  logic                 overflow_r;
`endif

  // Handshake: each stage may load when it is empty or its successor drains
  always_comb begin
    s2_take_s = !s2_valid_r || out_ready;
    s1_take_s = !s1_valid_r || s2_take_s;
    accept_s  = in_valid && s1_take_s;
    advance_s = s1_valid_r && s2_take_s;
  end

  assign in_ready  = s1_take_s;
  assign out_valid = s2_valid_r;
  assign result    = result_r;
  assign carryout  = carryout_r;
`ifdef CLA_OVERFLOW_EN
  assign overflow  = overflow_r;
`endif

  // Operand conditioning and per-bit propagate/generate
  always_comb begin
    b_eff_s   = B;
    cin_eff_s = carryin;
    if (sub == OP_SUB) begin
      b_eff_s   = ~B;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = B;
      cin_eff_s = carryin;
    end
    p_s = A ^ b_eff_s;
    g_s = A & b_eff_s;
  end

  for (genvar k = 0; k < NUMGROUPS; k++) begin : g_s1_grp
    cla_group #(
      .GROUPBITS (GROUPBITS)
    ) u_pg (
      .mode (GRP_MODE_PG),
      .p    (p_s[k*GROUPBITS +: GROUPBITS]),
      .g    (g_s[k*GROUPBITS +: GROUPBITS]),
      .cin  (1'b0),
      .gp   (gp_s[k]),
      .gg   (gg_s[k]),
      .sum  (unused_s1_sum_s[k*GROUPBITS +: GROUPBITS])
    );
  end

  // Stage 1 registers: load only on accept so bubbles carry no data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_p_r     <= '0;
      s1_g_r     <= '0;
      s1_gp_r    <= '0;
      s1_gg_r    <= '0;
      s1_cin_r   <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      s1_a_msb_r <= 1'b0;
`endif
    end else if (s1_take_s) begin
      s1_valid_r <= in_valid;
      if (accept_s) begin
        s1_p_r     <= p_s;
        s1_g_r     <= g_s;
        s1_gp_r    <= gp_s;
        s1_gg_r    <= gg_s;
        s1_cin_r   <= cin_eff_s;
`ifdef CLA_OVERFLOW_EN
        s1_a_msb_r <= A[NUMBITS-1];
`endif
      end
    end
  end

  // Second-level lookahead: carry into each group from registered GP/GG
  always_comb begin
    logic c_v;
    grp_c_s = '0;
    c_v     = s1_cin_r;
    for (int k = 0; k < NUMGROUPS; k++) begin
      grp_c_s[k] = c_v;
      c_v        = s1_gg_r[k] | (s1_gp_r[k] & c_v);
    end
    grp_c_s[NUMGROUPS] = c_v;
  end

  for (genvar k = 0; k < NUMGROUPS; k++) begin : g_s2_grp
    cla_group #(
      .GROUPBITS (GROUPBITS)
    ) u_sum (
      .mode (GRP_MODE_SUM),
      .p    (s1_p_r[k*GROUPBITS +: GROUPBITS]),
      .g    (s1_g_r[k*GROUPBITS +: GROUPBITS]),
      .cin  (grp_c_s[k]),
      .gp   (unused_s2_gp_s[k]),
      .gg   (unused_s2_gg_s[k]),
      .sum  (sum_s[k*GROUPBITS +: GROUPBITS])
    );
  end

`ifdef CLA_OVERFLOW_EN
  // A and Beff share a sign exactly when the MSB propagate bit is clear
  always_comb begin
    ovf_s = !s1_p_r[NUMBITS-1] && (sum_s[NUMBITS-1] != s1_a_msb_r);
  end
`endif

  // Stage 2 registers: hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= '0;
      carryout_r <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      overflow_r <= 1'b0;
`endif
    end else if (s2_take_s) begin
      s2_valid_r <= s1_valid_r;
      if (advance_s) begin
        result_r   <= sum_s;
        carryout_r <= grp_c_s[NUMGROUPS];
`ifdef CLA_OVERFLOW_EN
        overflow_r <= ovf_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: directed cases on a 16/4 instance, randomized
// valid/ready sweep on a 32/8 instance, both scored against an arithmetic
// reference model with in-order expectation queues.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  // 16-bit instance
  logic        in_valid16, in_ready16, sub16, cin16, out_valid16, out_ready16, co16;
  logic [15:0] a16, b16, res16;
  // 32-bit instance
  logic        in_valid32, in_ready32, sub32, cin32, out_valid32, out_ready32, co32;
  logic [31:0] a32, b32, res32;
`ifdef CLA_OVERFLOW_EN
  logic        ov16, ov32;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_out16  = 0;
  int n_out32  = 0;
  exp_t q16[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.NUMBITS(16), .GROUPBITS(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .carryin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .result(res16), .carryout(co16)
`ifdef CLA_OVERFLOW_EN
    , .overflow(ov16)
`endif
  );

  pipelined_cla_adder #(.NUMBITS(32), .GROUPBITS(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .carryin(cin32), .sub(sub32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .result(res32), .carryout(co32)
`ifdef CLA_OVERFLOW_EN
    , .overflow(ov32)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: integer sum/difference and signed range test
  function automatic exp_t ref_model(input int nb, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
    exp_t r;
    longint unsigned mask, au, bu, full;
    longint sa, sb, sv, half;
    mask = (64'd1 << nb) - 64'd1;
    au   = longint'(a) & mask;
    bu   = longint'(b) & mask;
    half = longint'(64'd1 << (nb - 1));
    if (sub) begin
      full = (au - bu) & mask;
      r.co = (au >= bu);
    end else begin
      full = au + bu + longint'(cin);
      r.co = full[nb];
    end
    r.res = 32'(full & mask);
    sa = longint'(au); if (sa >= half) sa = sa - 2 * half;
    sb = longint'(bu); if (sb >= half) sb = sb - 2 * half;
    sv = sub ? (sa - sb) : (sa + sb + longint'(cin));
    r.ov = (sv >= half) || (sv < -half);
    return r;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard for the 16-bit instance, sampled mid-cycle
  logic        stall16 = 1'b0;
  logic [15:0] hold_res16;
  logic        hold_co16;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q16.delete();
      stall16 = 1'b0;
    end else begin
      if (stall16) begin
        check_val("hold16_res", 64'(res16), 64'(hold_res16));
        check_val("hold16_co", 64'(co16), 64'(hold_co16));
      end
      if (out_valid16 && out_ready16) begin
        n_out16++;
        check_val("sb16_nonempty", 64'(q16.size() != 0), 64'd1);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          check_val("sb16_res", 64'(res16), 64'(e.res[15:0]));
          check_val("sb16_co", 64'(co16), 64'(e.co));
`ifdef CLA_OVERFLOW_EN
          check_val("sb16_ov", 64'(ov16), 64'(e.ov));
`endif
        end
      end
      if (in_valid16 && in_ready16) q16.push_back(ref_model(16, 32'(a16), 32'(b16), cin16, sub16));
      stall16    = out_valid16 && !out_ready16;
      hold_res16 = res16;
      hold_co16  = co16;
    end
  end

  // Scoreboard for the 32-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q32.delete();
    end else begin
      if (out_valid32 && out_ready32) begin
        n_out32++;
        check_val("sb32_nonempty", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          check_val("sb32_res", 64'(res32), 64'(e.res));
          check_val("sb32_co", 64'(co32), 64'(e.co));
`ifdef CLA_OVERFLOW_EN
          check_val("sb32_ov", 64'(ov32), 64'(e.ov));
`endif
        end
      end
      if (in_valid32 && in_ready32) q32.push_back(ref_model(32, a32, b32, cin32, sub32));
    end
  end

  // Single op on the idle 16-bit pipe, checking latency and the fixed answer
  task automatic run_single16(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub, input logic [15:0] exp_res,
                              input logic exp_co, input logic exp_ov);
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    check_val({tag, "_valid_e1"}, 64'(out_valid16), 64'd0);
    @(posedge clk); #1;
    check_val({tag, "_valid_e2"}, 64'(out_valid16), 64'd1);
    check_val({tag, "_res"}, 64'(res16), 64'(exp_res));
    check_val({tag, "_co"}, 64'(co16), 64'(exp_co));
`ifdef CLA_OVERFLOW_EN
    check_val({tag, "_ov"}, 64'(ov16), 64'(exp_ov));
`else
    if (exp_ov === 1'bx) $display("note: unreachable");
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int idx, base, acc, rdy;
    logic [15:0] ops_a[4];
    logic [15:0] ops_b[4];
    logic        ops_s[4];

    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_val("rst_res16", 64'(res16), 64'd0);
    check_val("rst_co16", 64'(co16), 64'd0);
    check_val("rst_valid16", 64'(out_valid16), 64'd0);
    check_val("rst_res32", 64'(res32), 64'd0);
    rst_n = 1'b1;
    check_val("rst_in_ready16", 64'(in_ready16), 64'd1);
    @(posedge clk); #1;

    // Directed cases
    run_single16("add", 16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    run_single16("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single16("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_single16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: 4 back-to-back ops, consumer stalled for 3 cycles
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = 16'($urandom); ops_b[i] = 16'($urandom); ops_s[i] = 1'($urandom);
    end
    idx = 0; base = n_out16;
    for (int c = 0; c < 20 && (idx < 4 || (n_out16 - base) < 4); c++) begin
      out_ready16 = (c >= 3);
      if (idx < 4) begin
        a16 = ops_a[idx]; b16 = ops_b[idx]; sub16 = ops_s[idx]; cin16 = 1'($urandom);
        in_valid16 = 1'b1;
      end else begin
        in_valid16 = 1'b0;
      end
      #1;
      rdy = int'(in_ready16);
      if (c == 2) check_val("bp_in_ready_full", 64'(in_ready16), 64'd0);
      @(posedge clk); #1;
      if (in_valid16 && rdy != 0) idx++;
    end
    in_valid16 = 1'b0;
    check_val("bp_accepted", 64'(idx), 64'd4);
    check_val("bp_emitted", 64'(n_out16 - base), 64'd4);

    // Reset with both stages holding ops
    out_ready16 = 1'b0;
    a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h4321; b16 = 16'h1111;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    check_val("mid_full_valid", 64'(out_valid16), 64'd1);
    check_val("mid_full_res", 64'(res16), 64'h0002);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(out_valid16), 64'd0);
    check_val("mid_rst_res", 64'(res16), 64'd0);
    check_val("mid_rst_co", 64'(co16), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready16 = 1'b1;
    base = n_out16;
    repeat (5) @(posedge clk);
    #1;
    check_val("mid_no_stale", 64'(n_out16 - base), 64'd0);

    // Random valid/ready sweep on the 32-bit instance
    for (int c = 0; c < 600; c++) begin
      in_valid32 = ($urandom_range(0, 9) < 7);
      out_ready32 = ($urandom_range(0, 9) < 7);
      a32 = pick32(); b32 = pick32(); cin32 = 1'($urandom); sub32 = 1'($urandom);
      @(posedge clk); #1;
    end

    // Full-throughput window
    acc = 0; base = n_out32;
    in_valid32 = 1'b1; out_ready32 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      a32 = pick32(); b32 = pick32(); cin32 = 1'($urandom); sub32 = 1'($urandom);
      #1;
      if (in_ready32) acc++;
      @(posedge clk); #1;
    end
    in_valid32 = 1'b0;
    check_val("tput_accepts", 64'(acc), 64'd200);
    check_val("tput_outputs", 64'((n_out32 - base) >= 198), 64'd1);

    repeat (5) @(posedge clk);
    #1;
    check_val("drain16_empty", 64'(q16.size()), 64'd0);
    check_val("drain32_empty", 64'(q32.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
